// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and scoreboard for the 32x32 register file: merges datapath
// writebacks with buffered long-latency results and raises cpu_stall on hazards.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        reg_clk,
  input  logic        rst_n,
  input  logic        cpu_w_req,
  input  logic [4:0]  cpu_rdc,
  input  logic [31:0] cpu_wdata,
  input  logic [4:0]  rs_c,
  input  logic [4:0]  rt_c,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rdc,
  output logic        lu_issue_ready,
  input  logic        lu_done,
  input  logic [4:0]  lu_done_rdc,
  input  logic [31:0] lu_done_data,
  output logic        lu_done_ready,
  output logic        reg_w,
  output logic [4:0]  RdC,
  output logic [31:0] Rd_data_in,
  output logic        cpu_stall
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  logic [31:0]   busy_q, busy_d;
  logic [4:0]    fifo_rdc_q  [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [SW-1:0] starve_q, starve_d;

  logic        fifo_ne_s;
  logic [4:0]  head_rdc_s;
  logic [31:0] head_data_s;
  logic        issue_ready_s;
  logic        done_ready_s;
  logic        issue_set_s;
  logic        push_s;
  logic        starve_grant_s;
  logic        hazard_s;
  logic        stall_s;
  logic        cpu_win_s;
  logic        drain_s;
  logic        outst_dec_s;

  // Readiness, hazard detection and write-port arbitration
  always_comb begin
    fifo_ne_s      = (count_q != {CW{1'b0}});
    head_rdc_s     = fifo_rdc_q[rd_ptr_q];
    head_data_s    = fifo_data_q[rd_ptr_q];
    issue_ready_s  = !rst_n && !busy_q[lu_issue_rdc] && (outst_q < DEPTH_C);
    done_ready_s   = !rst_n && (count_q < DEPTH_C);
    issue_set_s    = lu_issue && issue_ready_s && (lu_issue_rdc != 5'd0);
    push_s         = lu_done && done_ready_s && (lu_done_rdc != 5'd0);
    starve_grant_s = (starve_q == STARVE_C) && fifo_ne_s;
    hazard_s       = busy_q[rs_c] | busy_q[rt_c] | (cpu_w_req & busy_q[cpu_rdc]);
    stall_s        = !rst_n && (hazard_s || starve_grant_s);
    // stall_s already covers the starve grant, so the cpu can only win when the FIFO is not forced
    cpu_win_s      = !rst_n && cpu_w_req && (cpu_rdc != 5'd0) && !stall_s;
    drain_s        = !rst_n && fifo_ne_s && !cpu_win_s;
    outst_dec_s    = drain_s && (outst_q != {CW{1'b0}});
  end

  // Write-port drive from the arbitration winner
  always_comb begin
    reg_w          = cpu_win_s | drain_s;
    cpu_stall      = stall_s;
    lu_issue_ready = issue_ready_s;
    lu_done_ready  = done_ready_s;
    if (cpu_win_s) begin
      RdC        = cpu_rdc;
      Rd_data_in = cpu_wdata;
    end else begin
      RdC        = head_rdc_s;
      Rd_data_in = head_data_s;
    end
  end

  // Next-state computation for scoreboard, pointers and counters
  always_comb begin
    busy_d = busy_q;
    if (drain_s) begin
      busy_d[head_rdc_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_set_s) begin
      busy_d[lu_issue_rdc] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;

    wr_ptr_d = push_s  ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = drain_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    case ({push_s, drain_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({issue_set_s, outst_dec_s})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (drain_s || !fifo_ne_s) begin
      starve_d = {SW{1'b0}};
    end else if (cpu_win_s && (starve_q != STARVE_C)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge reg_clk) begin
    if (rst_n) begin
      busy_q   <= 32'd0;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      outst_q  <= {CW{1'b0}};
      starve_q <= {SW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rdc_q[i]  <= 5'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else begin
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      starve_q <= starve_d;
      if (push_s) begin
        fifo_rdc_q[wr_ptr_q]  <= lu_done_rdc;
        fifo_data_q[wr_ptr_q] <= lu_done_data;
      end else begin
        fifo_rdc_q[wr_ptr_q]  <= fifo_rdc_q[wr_ptr_q];
        fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter: one record per clock cycle of
// inputs and the expected combinational outputs inside that cycle.
module tb_regfile_wb_arbiter;

  logic        reg_clk;
  logic        rst_n;
  logic        cpu_w_req;
  logic [4:0]  cpu_rdc;
  logic [31:0] cpu_wdata;
  logic [4:0]  rs_c;
  logic [4:0]  rt_c;
  logic        lu_issue;
  logic [4:0]  lu_issue_rdc;
  logic        lu_issue_ready;
  logic        lu_done;
  logic [4:0]  lu_done_rdc;
  logic [31:0] lu_done_data;
  logic        lu_done_ready;
  logic        reg_w;
  logic [4:0]  RdC;
  logic [31:0] Rd_data_in;
  logic        cpu_stall;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .reg_clk(reg_clk), .rst_n(rst_n),
    .cpu_w_req(cpu_w_req), .cpu_rdc(cpu_rdc), .cpu_wdata(cpu_wdata),
    .rs_c(rs_c), .rt_c(rt_c),
    .lu_issue(lu_issue), .lu_issue_rdc(lu_issue_rdc), .lu_issue_ready(lu_issue_ready),
    .lu_done(lu_done), .lu_done_rdc(lu_done_rdc), .lu_done_data(lu_done_data),
    .lu_done_ready(lu_done_ready),
    .reg_w(reg_w), .RdC(RdC), .Rd_data_in(Rd_data_in), .cpu_stall(cpu_stall)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  typedef struct {
    logic        rst;
    logic        wq;
    logic [4:0]  wrdc;
    logic [31:0] wdata;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        iss;
    logic [4:0]  irdc;
    logic        dn;
    logic [4:0]  drdc;
    logic [31:0] ddata;
    logic        e_w;
    logic [4:0]  e_rdc;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_irdy;
    logic        e_drdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic rst, input logic wq, input logic [4:0] wrdc, input logic [31:0] wdata,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic iss, input logic [4:0] irdc,
    input logic dn, input logic [4:0] drdc, input logic [31:0] ddata,
    input logic e_w, input logic [4:0] e_rdc, input logic [31:0] e_data,
    input logic e_stall, input logic e_irdy, input logic e_drdy);
    vec_t v;
    v.rst = rst; v.wq = wq; v.wrdc = wrdc; v.wdata = wdata;
    v.rs = rs; v.rt = rt; v.iss = iss; v.irdc = irdc;
    v.dn = dn; v.drdc = drdc; v.ddata = ddata;
    v.e_w = e_w; v.e_rdc = e_rdc; v.e_data = e_data;
    v.e_stall = e_stall; v.e_irdy = e_irdy; v.e_drdy = e_drdy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, got, exp);
    end
  endtask

  // Drive one record, check mid-cycle at the falling edge, then advance a clock.
  task automatic run_vec(input vec_t v, input int idx);
    rst_n        = v.rst;
    cpu_w_req    = v.wq;
    cpu_rdc      = v.wrdc;
    cpu_wdata    = v.wdata;
    rs_c         = v.rs;
    rt_c         = v.rt;
    lu_issue     = v.iss;
    lu_issue_rdc = v.irdc;
    lu_done      = v.dn;
    lu_done_rdc  = v.drdc;
    lu_done_data = v.ddata;
    @(negedge reg_clk);
    chk("reg_w", idx, {31'd0, reg_w}, {31'd0, v.e_w});
    chk("cpu_stall", idx, {31'd0, cpu_stall}, {31'd0, v.e_stall});
    chk("lu_issue_ready", idx, {31'd0, lu_issue_ready}, {31'd0, v.e_irdy});
    chk("lu_done_ready", idx, {31'd0, lu_done_ready}, {31'd0, v.e_drdy});
    if (v.e_w) begin
      chk("RdC", idx, {27'd0, RdC}, {27'd0, v.e_rdc});
      chk("Rd_data_in", idx, Rd_data_in, v.e_data);
    end
    @(posedge reg_clk);
    #1;
  endtask

  initial begin
    vec_t h;
    // Columns: rst, wq,wrdc,wdata, rs,rt, iss,irdc, dn,drdc,ddata | e_w,e_rdc,e_data, e_stall,e_irdy,e_drdy
    // Reset held with every request high
    add(1'b1, 1'b1,5'd3,32'h1111, 5'd0,5'd0, 1'b1,5'd5, 1'b1,5'd6,32'h2222, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0);
    add(1'b1, 1'b1,5'd3,32'h1111, 5'd0,5'd0, 1'b1,5'd5, 1'b1,5'd6,32'h2222, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd5,5'd6, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    // RAW on r5 through a long-latency return
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd5, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b0,5'd0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd5,32'hDEADBEEF, 1'b1,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    // Starvation: r7 waits in the FIFO while the cpu writes r3
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd7, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b1,5'd7,32'h77,   1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b1,5'd3,32'hA1,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd3,32'hA1, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b1,5'd3,32'hA2,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd3,32'hA2, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b1,5'd3,32'hA3,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd3,32'hA3, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b1,5'd3,32'hA4,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd7,32'h77, 1'b1,1'b1,1'b1);
    add(1'b0, 1'b1,5'd3,32'hA4,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd3,32'hA4, 1'b0,1'b1,1'b1);
    // Outstanding limit, busy-issue block, WAW
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd10, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd11, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd12, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd10, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd13, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b1,5'd11,32'h55,  5'd0,5'd0, 1'b1,5'd14, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1);
    // Register 0: cpu write and return both ignored
    add(1'b0, 1'b1,5'd0,32'h123,  5'd0,5'd0, 1'b0,5'd0, 1'b1,5'd0,32'hBAD,  1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1);
    // Fill the FIFO while the cpu wins, then forced drain at full
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b1,5'd10,32'h1010, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1);
    add(1'b0, 1'b1,5'd3,32'hB1,   5'd0,5'd0, 1'b0,5'd0, 1'b1,5'd11,32'h1111, 1'b1,5'd3,32'hB1, 1'b0,1'b0,1'b1);
    add(1'b0, 1'b1,5'd3,32'hB2,   5'd0,5'd0, 1'b0,5'd0, 1'b1,5'd12,32'h1212, 1'b1,5'd3,32'hB2, 1'b0,1'b0,1'b1);
    add(1'b0, 1'b1,5'd3,32'hB3,   5'd0,5'd0, 1'b0,5'd0, 1'b1,5'd13,32'h1313, 1'b1,5'd3,32'hB3, 1'b0,1'b0,1'b1);
    add(1'b0, 1'b1,5'd3,32'hB4,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd10,32'h1010, 1'b1,1'b0,1'b0);
    add(1'b0, 1'b1,5'd3,32'hB4,   5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd3,32'hB4, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd11,32'h1111, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd12,32'h1212, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b1,5'd13,32'h1313, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    // Out-of-order return: issue 9, 12; return 12, 9
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd9, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,5'd12, 1'b0,5'd0,32'h0,   1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd9,5'd12, 1'b0,5'd0, 1'b1,5'd12,32'hC12, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd9,5'd9, 1'b0,5'd0, 1'b1,5'd9,32'hC9,   1'b1,5'd12,32'hC12, 1'b1,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd12,5'd12, 1'b0,5'd0, 1'b0,5'd0,32'h0,  1'b1,5'd9,32'hC9, 1'b0,1'b1,1'b1);
    add(1'b0, 1'b0,5'd0,32'h0,    5'd9,5'd9, 1'b0,5'd0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1);

    rst_n = 1'b1; cpu_w_req = 1'b0; cpu_rdc = 5'd0; cpu_wdata = 32'd0;
    rs_c = 5'd0; rt_c = 5'd0; lu_issue = 1'b0; lu_issue_rdc = 5'd0;
    lu_done = 1'b0; lu_done_rdc = 5'd0; lu_done_data = 32'd0;
    @(posedge reg_clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset mid-operation: r20 pending in the FIFO, r21 reserved
    h = vecs[2];
    h.rs = 5'd0; h.rt = 5'd0;
    h.iss = 1'b1; h.irdc = 5'd20;
    run_vec(h, 100);
    h.iss = 1'b1; h.irdc = 5'd21; h.dn = 1'b1; h.drdc = 5'd20; h.ddata = 32'h2020;
    run_vec(h, 101);
    h.rst = 1'b1; h.iss = 1'b0; h.irdc = 5'd0; h.dn = 1'b0; h.drdc = 5'd0;
    h.rs = 5'd20; h.rt = 5'd21;
    h.e_w = 1'b0; h.e_stall = 1'b0; h.e_irdy = 1'b0; h.e_drdy = 1'b0;
    run_vec(h, 102);
    run_vec(h, 103);
    h.rst = 1'b0; h.e_irdy = 1'b1; h.e_drdy = 1'b1;
    run_vec(h, 104);
    run_vec(h, 105);
    h.rs = 5'd0; h.rt = 5'd0; h.iss = 1'b1; h.irdc = 5'd21;
    run_vec(h, 106);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
